// File: rtl/osnt_pkg.sv
// Shared widths and FSM encoding for the OSNT timestamp insertion path.
package osnt_pkg;

  localparam int AXIS_DATA_WIDTH_DEF  = 256;
  localparam int AXIS_TUSER_WIDTH_DEF = 128;
  localparam int TIMESTAMP_WIDTH_DEF  = 64;
  localparam int TS_TUSER_LSB_DEF     = 32;

  typedef enum logic {
    ST_SOF = 1'b0,
    ST_MID = 1'b1
  } pkt_state_e;

endpackage

// File: rtl/axis_skid_slice.sv
// One-deep registered AXI-Stream slice: output register plus a skid entry,
// with a registered ready so the upstream path is cut as well.
module axis_skid_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_vld_q, out_vld_d;
  logic             skid_full_q, skid_full_d;
  logic             rdy_q;
  logic             in_fire;

  assign in_fire = s_valid_i & rdy_q;

  // Skid only fills while the output is stalled; ready being !skid_full
  // guarantees no input arrives while the skid is being drained.
  always_comb begin
    out_d       = out_q;
    out_vld_d   = out_vld_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    if (!out_vld_q || m_ready_i) begin
      if (skid_full_q) begin
        out_d       = skid_q;
        out_vld_d   = 1'b1;
        skid_full_d = 1'b0;
      end else if (in_fire) begin
        out_d     = s_data_i;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d      = s_data_i;
      skid_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q       <= '0;
      skid_q      <= '0;
      out_vld_q   <= 1'b0;
      skid_full_q <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_vld_q   <= out_vld_d;
      skid_full_q <= skid_full_d;
      rdy_q       <= !skid_full_d;
    end
  end

  assign s_ready_o = rdy_q;
  assign m_data_o  = out_q;
  assign m_valid_o = out_vld_q;

endmodule

// File: rtl/osnt_tstamp_inserter.sv
// Stamps the first beat of each packet with the global timestamp (plus a
// fixed latency offset) and counts stamped packets.
module osnt_tstamp_inserter
  import osnt_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = AXIS_DATA_WIDTH_DEF,
  parameter int C_AXIS_TUSER_WIDTH = AXIS_TUSER_WIDTH_DEF,
  parameter int TIMESTAMP_WIDTH    = TIMESTAMP_WIDTH_DEF,
  parameter int TS_TUSER_LSB       = TS_TUSER_LSB_DEF,
  parameter logic [TIMESTAMP_WIDTH-1:0] STAMP_OFFSET = '0
) (
  input  logic                            axi_aclk,
  input  logic                            axi_reset,
  input  logic [TIMESTAMP_WIDTH-1:0]      tstamp,
  input  logic                            stamp_en,
  input  logic                            pkt_cnt_clr,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [31:0]                     pkt_cnt
);

  localparam int STRB_W    = C_AXIS_DATA_WIDTH / 8;
  localparam int PAYLOAD_W = C_AXIS_DATA_WIDTH + STRB_W + C_AXIS_TUSER_WIDTH + 1;

  pkt_state_e                   state_q, state_d;
  logic                         in_fire;
  logic                         stamp_sel;
  logic [TIMESTAMP_WIDTH-1:0]   ts;
  logic [C_AXIS_TUSER_WIDTH-1:0] tuser_ins;
  logic [31:0]                  pkt_cnt_q, pkt_cnt_d;
  logic [PAYLOAD_W-1:0]         s_payload, m_payload;

  assign in_fire   = s_axis_tvalid & s_axis_tready;
  assign stamp_sel = (state_q == ST_SOF) & stamp_en;
  assign ts        = tstamp + STAMP_OFFSET;

  always_comb begin
    tuser_ins = s_axis_tuser;
    if (stamp_sel) begin
      tuser_ins[TS_TUSER_LSB +: TIMESTAMP_WIDTH] = ts;
    end
  end

  always_comb begin
    state_d = state_q;
    if (in_fire) begin
      state_d = s_axis_tlast ? ST_SOF : ST_MID;
    end
  end

  // Clear wins over a coincident increment.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pkt_cnt_clr) begin
      pkt_cnt_d = '0;
    end else if (in_fire && stamp_sel) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q   <= ST_SOF;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign s_payload = {s_axis_tdata, s_axis_tstrb, tuser_ins, s_axis_tlast};

  axis_skid_slice #(
    .WIDTH (PAYLOAD_W)
  ) u_slice (
    .clk_i     (axi_aclk),
    .rst_i     (axi_reset),
    .s_data_i  (s_payload),
    .s_valid_i (s_axis_tvalid),
    .s_ready_o (s_axis_tready),
    .m_data_o  (m_payload),
    .m_valid_o (m_axis_tvalid),
    .m_ready_i (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast} = m_payload;
  assign pkt_cnt = pkt_cnt_q;

endmodule
